seq_1011_tx: RTL and testbench

Serial framer that emits `DATA_W`-bit words on a single-bit line, one bit per clock. Each word is preceded by the sync pattern 1011, and bit-stuffing keeps 1011 from appearing anywhere else in the stream. An overlapping Mealy 1011 detector on the far end therefore fires exactly once per frame, on the last sync bit. It is the transmit end of the 1011 sync link and sits between a valid/ready word source and the serial line.

---
 rtl/seq_1011_tx_if.sv | 36 +++
 rtl/seq_1011_tx.sv | 119 +++++++++++
 tb/tb_seq_1011_tx.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_1011_tx_if.sv
// Word-source / serial-line bundle for the 1011 sync framer.
// Latency: n/a (wires only).
// Backpressure: source holds data_in/valid_in until ready_out; the serial side has no backpressure.
//   master: word source + line observer (drives data_in/valid_in)
//   slave : the framer (drives ready_out, tx_out, busy, sync_mark, frame_done)
interface seq_1011_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic              ready_out;
    logic              tx_out;
    logic              busy;
    logic              sync_mark;
    logic              frame_done;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  tx_out,
        input  busy,
        input  sync_mark,
        input  frame_done
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output tx_out,
        output busy,
        output sync_mark,
        output frame_done
    );
endinterface

// File: rtl/seq_1011_tx.sv
// Serial framer: sends each word as sync 1011 + MSB-first payload, bit-stuffing so 1011 appears only as sync.
// Latency: word accepted at edge E -> first sync bit on tx_out after edge E+1; DATA_W+4 bits per unstuffed frame.
// Backpressure: ready_out high in IDLE and in the cycle before an unstuffed final payload bit; otherwise held off.
//   Ports: clk, rst (async, active-high); bus (slave modport): data_in, valid_in, ready_out,
//          tx_out, busy, sync_mark, frame_done.
module seq_1011_tx #(
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    seq_1011_tx_if.slave  bus
);
    localparam int IDX_W = $clog2(DATA_W);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    // Sync bit index 0 is the MSB of this constant.
    localparam logic [3:0] SYNC_PAT = 4'b1011;

    logic [1:0]        state;
    logic [1:0]        sync_idx;
    logic [IDX_W-1:0]  data_idx;
    logic [DATA_W-1:0] shreg;
    logic              tx_q;
    logic [2:0]        hist;     // hist[0] is the most recently sent bit
    logic              sync_mark_q;
    logic              frame_done_q;

    logic cand;
    logic stuff;
    logic last_bit;
    logic ready;
    logic accept;
    logic tx_nxt;

    always_comb begin
        cand = 1'b0;
        case (state)
            ST_SYNC: cand = SYNC_PAT[2'd3 - sync_idx];
            ST_DATA: cand = shreg[DATA_W-1];
            default: cand = 1'b0;
        endcase

        // A 1 after 101 would complete 1011; the last sync bit is the only place that is allowed.
        stuff = (state != ST_IDLE) && (hist == 3'b101) && cand
                && !((state == ST_SYNC) && (sync_idx == 2'd3));

        last_bit = (state == ST_DATA) && (data_idx == '0) && !stuff;
        ready    = (state == ST_IDLE) || last_bit;
        accept   = bus.valid_in && ready;
        tx_nxt   = stuff ? 1'b0 : cand;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            sync_idx     <= 2'd0;
            data_idx     <= '0;
            shreg        <= '0;
            tx_q         <= 1'b0;
            hist         <= 3'b000;
            sync_mark_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            tx_q         <= tx_nxt;
            hist         <= {hist[1:0], tx_nxt};
            // Sync bit 3 is never stuffed, so the mark lines up with it unconditionally.
            sync_mark_q  <= (state == ST_SYNC) && (sync_idx == 2'd3);
            frame_done_q <= last_bit;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shreg    <= bus.data_in;
                        sync_idx <= 2'd0;
                        state    <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (!stuff) begin
                        if (sync_idx == 2'd3) begin
                            data_idx <= IDX_W'(DATA_W - 1);
                            state    <= ST_DATA;
                        end else begin
                            sync_idx <= sync_idx + 2'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (!stuff) begin
                        if (data_idx == '0) begin
                            // Back-to-back: next word's sync starts on the very next edge.
                            if (accept) begin
                                shreg    <= bus.data_in;
                                sync_idx <= 2'd0;
                                state    <= ST_SYNC;
                            end else begin
                                state    <= ST_IDLE;
                            end
                        end else begin
                            shreg    <= {shreg[DATA_W-2:0], 1'b0};
                            data_idx <= data_idx - 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready_out  = ready;
    assign bus.tx_out     = tx_q;
    assign bus.busy       = (state == ST_SYNC) || (state == ST_DATA);
    assign bus.sync_mark  = sync_mark_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seq_1011_tx.sv
// Bench for seq_1011_tx: directed frame table, back-to-back and mid-frame reset sequences,
// then random traffic checked by an overlapping 1011 detector and a stuffing reference.
module tb_seq_1011_tx;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_1011_tx_if #(.DATA_W(DW)) bus ();

    seq_1011_tx #(.DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        logic [7:0]  word;
        int          len;   // frame length in bits
        logic [31:0] exp;   // frame bits MSB-first, followed by one idle 0
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Stuffed payload bits expected after the sync pattern (history starts at 011).
    function automatic void encode(input logic [7:0] w, output logic [31:0] bits, output int n);
        logic [2:0] h;
        logic       c;
        logic       b;
        int         i;
        h    = 3'b011;
        i    = 7;
        n    = 0;
        bits = '0;
        while (i >= 0) begin
            c = w[i];
            if (h == 3'b101 && c) begin
                b = 1'b0;
            end else begin
                b = c;
                i--;
            end
            bits = {bits[30:0], b};
            n++;
            h = {h[1:0], b};
        end
    endfunction

    // Sends one isolated frame and checks its stream, marks, busy span and ready window.
    task automatic run_frame(input vec_t v);
        logic [31:0] cap;
        logic [31:0] sm;
        logic [31:0] fd;
        logic [31:0] rm;
        int          bc;
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.data_in  = v.word;
        chk({v.name, "_idle_ready"}, 32'(bus.ready_out), 32'd1);
        @(negedge clk);
        bus.valid_in = 1'b0;
        cap = '0; sm = '0; fd = '0; rm = '0; bc = 0;
        for (int p = 0; p <= v.len + 1; p++) begin
            if (p > 0) begin
                @(negedge clk);
                cap = {cap[30:0], bus.tx_out};
            end
            if (bus.sync_mark)                  sm[p] = 1'b1;
            if (bus.frame_done)                 fd[p] = 1'b1;
            if (p < v.len && bus.ready_out)     rm[p] = 1'b1;
            if (bus.busy)                       bc++;
        end
        chk({v.name, "_stream"}, cap, v.exp);
        chk({v.name, "_sync_mark"}, sm, 32'h1 << 4);
        chk({v.name, "_frame_done"}, fd, 32'h1 << v.len);
        chk({v.name, "_ready_win"}, rm, 32'h1 << (v.len - 1));
        chk({v.name, "_busy_cycles"}, 32'(bc), 32'(v.len));
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] cap;
        logic [31:0] sm;
        logic [31:0] fd;
        int          acc;
        int          cnt;
        int          nacc;
        int          hits;
        logic        mon_done;
        logic [7:0]  q[$];

        tbl[0] = '{"w00", 8'h00, 12, 32'(13'b1011000000000)};
        tbl[1] = '{"w7f", 8'h7F, 18, 32'(19'b1011010101010101010)};
        tbl[2] = '{"wa5", 8'hA5, 12, 32'(13'b1011101001010)};
        tbl[3] = '{"wff", 8'hFF, 12, 32'(13'b1011111111110)};
        tbl[4] = '{"w0b", 8'h0B, 13, 32'(14'b10110000101010)};

        // Reset held with a pending word.
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hFF;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(bus.tx_out), 32'd0);
        chk("rst_ready", 32'(bus.ready_out), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sync_mark", 32'(bus.sync_mark), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        bus.valid_in = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_idle_busy", 32'(bus.busy), 32'd0);

        for (int k = 0; k < 5; k++) run_frame(tbl[k]);

        // Back-to-back 0x05, 0x05 with valid held until the second acceptance.
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.data_in  = 8'h05;
        acc = 1;
        cap = '0; sm = '0; fd = '0;
        for (int p = 0; p <= 26; p++) begin
            @(negedge clk);
            if (acc == 2) bus.valid_in = 1'b0;
            if (p > 0) cap = {cap[30:0], bus.tx_out};
            if (bus.sync_mark)  sm[p] = 1'b1;
            if (bus.frame_done) fd[p] = 1'b1;
            if (bus.valid_in && bus.ready_out) acc++;
        end
        chk("b2b_stream", cap, 32'(26'b10110000010101011000001010));
        chk("b2b_sync_marks", sm, (32'h1 << 4) | (32'h1 << 17));
        chk("b2b_sync_count", 32'($countones(sm)), 32'd2);
        chk("b2b_frame_done", fd, (32'h1 << 12) | (32'h1 << 25));
        chk("b2b_accepts", 32'(acc), 32'd2);
        repeat (4) @(negedge clk);

        // Reset while payload is being sent.
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hA5;
        @(negedge clk);
        bus.valid_in = 1'b0;
        repeat (7) @(negedge clk);
        chk("midrst_pre_tx", 32'(bus.tx_out), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_tx", 32'(bus.tx_out), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        cnt = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 1) rst = 1'b0;
            if (bus.frame_done || bus.busy || bus.tx_out) cnt++;
        end
        chk("midrst_quiet", 32'(cnt), 32'd0);
        run_frame(tbl[2]);

        // Random traffic with detector and payload reference.
        nacc     = 0;
        hits     = 0;
        mon_done = 1'b0;
        @(negedge clk);
        fork
            begin : driver
                int gap;
                int wt;
                for (int k = 0; k < 2000; k++) begin
                    gap = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
                    if (gap > 0) begin
                        bus.valid_in = 1'b0;
                        repeat (gap) @(negedge clk);
                    end
                    bus.valid_in = 1'b1;
                    bus.data_in  = 8'($urandom_range(0, 255));
                    wt = 0;
                    while (!bus.ready_out && wt < 40) begin
                        @(negedge clk);
                        wt++;
                    end
                    if (!bus.ready_out) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL rnd_accept_timeout: ready_out=0 after %0d cycles, required 1", wt);
                    end else begin
                        q.push_back(bus.data_in);
                        nacc++;
                    end
                    @(negedge clk);
                end
                bus.valid_in = 1'b0;
                wt = 0;
                while (bus.busy && wt < 50) begin
                    @(negedge clk);
                    wt++;
                end
                repeat (4) @(negedge clk);
                mon_done = 1'b1;
            end
            begin : monitor
                logic [2:0]  dh;
                logic        hit;
                logic        inf;
                logic [31:0] rx;
                logic [31:0] eb;
                int          n;
                int          en;
                logic [7:0]  w;
                dh  = 3'b000;
                inf = 1'b0;
                rx  = '0;
                n   = 0;
                while (!mon_done) begin
                    @(negedge clk);
                    hit = (dh == 3'b101) && bus.tx_out;
                    chk("rnd_det_vs_sync_mark", 32'(hit), 32'(bus.sync_mark));
                    if (hit) hits++;
                    dh = {dh[1:0], bus.tx_out};
                    if (bus.sync_mark) begin
                        inf = 1'b1;
                        n   = 0;
                        rx  = '0;
                    end else if (inf) begin
                        rx = {rx[30:0], bus.tx_out};
                        n++;
                        if (bus.frame_done) begin
                            inf = 1'b0;
                            if (q.size() == 0) begin
                                chk("rnd_frame_without_word", 32'd1, 32'd0);
                            end else begin
                                w = q.pop_front();
                                encode(w, eb, en);
                                chk("rnd_payload_len", 32'(n), 32'(en));
                                chk("rnd_payload_bits", rx, eb);
                            end
                        end else if (n > 2 * DW) begin
                            chk("rnd_frame_overrun", 32'(n), 32'(2 * DW - 2));
                            inf = 1'b0;
                        end
                    end
                end
            end
        join

        chk("rnd_hits_vs_accepts", 32'(hits), 32'(nacc));
        chk("rnd_accepts", 32'(nacc), 32'd2000);
        chk("rnd_queue_drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
